// File: rtl/jacobi_phase_sequencer_if.sv
// Client/SRAM bundle between the Jacobi phase sequencer and its datapath clients.
// The master side is the sequencer; the slave side is the client phases and the SRAM port.
interface jacobi_phase_sequencer_if #(
   parameter int NUM_PHASES = 3,
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 256,
   parameter int ITER_W     = 8
);
   logic                           start;
   logic                           abort;
   logic [NUM_PHASES-1:0]          phase_done;
   logic                           converged;
   logic [NUM_PHASES*ADDR_W-1:0]   cl_raddr1;
   logic [NUM_PHASES*ADDR_W-1:0]   cl_raddr2;
   logic [NUM_PHASES-1:0]          cl_we;
   logic [NUM_PHASES*ADDR_W-1:0]   cl_waddr;
   logic [NUM_PHASES*DATA_W-1:0]   cl_wdata;
   logic [NUM_PHASES-1:0]          phase_en;
   logic [ADDR_W-1:0]              sram_raddr1;
   logic [ADDR_W-1:0]              sram_raddr2;
   logic                           sram_we;
   logic [ADDR_W-1:0]              sram_waddr;
   logic [DATA_W-1:0]              sram_wdata;
   logic [ITER_W-1:0]              iter_count;
   logic                           busy;
   logic                           all_done;
   logic                           timeout_err;

   modport master (
      input  start, abort, phase_done, converged,
      input  cl_raddr1, cl_raddr2, cl_we, cl_waddr, cl_wdata,
      output phase_en, sram_raddr1, sram_raddr2, sram_we, sram_waddr, sram_wdata,
      output iter_count, busy, all_done, timeout_err
   );

   modport slave (
      output start, abort, phase_done, converged,
      output cl_raddr1, cl_raddr2, cl_we, cl_waddr, cl_wdata,
      input  phase_en, sram_raddr1, sram_raddr2, sram_we, sram_waddr, sram_wdata,
      input  iter_count, busy, all_done, timeout_err
   );
endinterface

// File: rtl/jacobi_phase_sequencer.sv
// Phase sequencer and Y-SRAM port arbiter for the Jacobi solver: runs client phases in order,
// one bus-quiet gap cycle between phases, iteration counting and a per-phase watchdog.
//
//  state  | meaning
//  IDLE   | waiting for start, bus idle
//  RUN    | phase phase_idx enabled and owns the SRAM port
//  GAP    | one bus-quiet cycle between phases (or before DONE)
//  DONE   | run finished; iter_count / timeout_err held until start
module jacobi_phase_sequencer #(
   parameter int NUM_PHASES = 3,
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 256,
   parameter int ITER_W     = 8,
   parameter int MAX_ITERS  = 16,
   parameter int EARLY_STOP = 1,
   parameter int TIMEOUT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   jacobi_phase_sequencer_if.master bus
);
   localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_PHASES - 1);
   localparam logic [ITER_W-1:0]    MAX_CNT  = ITER_W'(MAX_ITERS);
   // Last watchdog value before all-ones: the phase has then been running 2^TIMEOUT_W-1 cycles.
   localparam logic [TIMEOUT_W-1:0] WD_LAST  = ~(TIMEOUT_W'(1));

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

   state_t                state;
   logic [IDX_W-1:0]      phase_idx;
   logic [NUM_PHASES-1:0] phase_en_q;
   logic [ITER_W-1:0]     iter_q;
   logic [TIMEOUT_W-1:0]  wd;
   logic                  busy_q;
   logic                  done_q;
   logic                  tmo_q;
   logic                  stop_q;

   logic                  done_hit;
   logic [ITER_W-1:0]     iter_next;
   logic [ADDR_W-1:0]     raddr1;
   logic [ADDR_W-1:0]     raddr2;
   logic [ADDR_W-1:0]     waddr;
   logic                  we;
   logic [DATA_W-1:0]     wdata;

   assign iter_next = iter_q + ITER_W'(1);

   always_comb begin
      done_hit = 1'b0;
      raddr1   = '1;
      raddr2   = '1;
      waddr    = '1;
      we       = 1'b0;
      wdata    = '0;
      for (int k = 0; k < NUM_PHASES; k++) begin
         if (phase_idx == IDX_W'(k)) begin
            done_hit = bus.phase_done[k];
            if (state == S_RUN) begin
               raddr1 = bus.cl_raddr1[k*ADDR_W +: ADDR_W];
               raddr2 = bus.cl_raddr2[k*ADDR_W +: ADDR_W];
               waddr  = bus.cl_waddr[k*ADDR_W +: ADDR_W];
               we     = bus.cl_we[k];
               wdata  = bus.cl_wdata[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         phase_idx  <= '0;
         phase_en_q <= '0;
         iter_q     <= '0;
         wd         <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tmo_q      <= 1'b0;
         stop_q     <= 1'b0;
      end else if (bus.abort) begin
         state      <= S_IDLE;
         phase_idx  <= '0;
         phase_en_q <= '0;
         iter_q     <= '0;
         wd         <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tmo_q      <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state      <= S_RUN;
                  phase_idx  <= '0;
                  phase_en_q <= NUM_PHASES'(1);
                  iter_q     <= '0;
                  wd         <= '0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  tmo_q      <= 1'b0;
                  stop_q     <= 1'b0;
               end
            end
            S_RUN: begin
               if (done_hit) begin
                  state      <= S_GAP;
                  phase_en_q <= '0;
                  wd         <= '0;
                  if (phase_idx == LAST_IDX) begin
                     iter_q    <= iter_next;
                     stop_q    <= (iter_next == MAX_CNT) || ((EARLY_STOP != 0) && bus.converged);
                     phase_idx <= '0;
                  end else begin
                     stop_q    <= 1'b0;
                     phase_idx <= phase_idx + IDX_W'(1);
                  end
               end else if (wd == WD_LAST) begin
                  state      <= S_DONE;
                  phase_en_q <= '0;
                  wd         <= '0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  tmo_q      <= 1'b1;
               end else begin
                  wd <= wd + TIMEOUT_W'(1);
               end
            end
            S_GAP: begin
               if (stop_q) begin
                  state  <= S_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  state      <= S_RUN;
                  phase_en_q <= NUM_PHASES'(1) << phase_idx;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.phase_en    = phase_en_q;
   assign bus.iter_count  = iter_q;
   assign bus.busy        = busy_q;
   assign bus.all_done    = done_q;
   assign bus.timeout_err = tmo_q;
   assign bus.sram_raddr1 = raddr1;
   assign bus.sram_raddr2 = raddr2;
   assign bus.sram_we     = we;
   assign bus.sram_waddr  = waddr;
   assign bus.sram_wdata  = wdata;
endmodule

// File: tb/tb_jacobi_phase_sequencer.sv
// Bench for jacobi_phase_sequencer: two instances (early stop on / off) share stimulus and are
// each compared every cycle against an abstract phase/iteration model.
module tb_jacobi_phase_sequencer;
   localparam int NP      = 3;
   localparam int AW      = 11;
   localparam int DW      = 256;
   localparam int MAX_IT  = 2;
   localparam int TMO_CYC = (1 << 4) - 1;

   logic clk;
   logic rst_n;
   logic start, abort, converged;
   logic [NP-1:0] pd;
   logic [AW-1:0] ra1 [NP];
   logic [AW-1:0] ra2 [NP];
   logic [AW-1:0] wa  [NP];
   logic [DW-1:0] wdt [NP];
   logic [NP-1:0] cwe;

   int checks = 0;
   int errors = 0;

   jacobi_phase_sequencer_if #(.NUM_PHASES(NP), .ADDR_W(AW), .DATA_W(DW), .ITER_W(8)) ife ();
   jacobi_phase_sequencer_if #(.NUM_PHASES(NP), .ADDR_W(AW), .DATA_W(DW), .ITER_W(8)) ifn ();

   jacobi_phase_sequencer #(.NUM_PHASES(NP), .ADDR_W(AW), .DATA_W(DW), .ITER_W(8),
      .MAX_ITERS(MAX_IT), .EARLY_STOP(1), .TIMEOUT_W(4)) dut_e (.clk(clk), .rst_n(rst_n), .bus(ife.master));
   jacobi_phase_sequencer #(.NUM_PHASES(NP), .ADDR_W(AW), .DATA_W(DW), .ITER_W(8),
      .MAX_ITERS(MAX_IT), .EARLY_STOP(0), .TIMEOUT_W(4)) dut_n (.clk(clk), .rst_n(rst_n), .bus(ifn.master));

   assign ife.start = start;       assign ifn.start = start;
   assign ife.abort = abort;       assign ifn.abort = abort;
   assign ife.phase_done = pd;     assign ifn.phase_done = pd;
   assign ife.converged = converged; assign ifn.converged = converged;
   assign ife.cl_we = cwe;         assign ifn.cl_we = cwe;
   assign ife.cl_raddr1 = {ra1[2], ra1[1], ra1[0]}; assign ifn.cl_raddr1 = {ra1[2], ra1[1], ra1[0]};
   assign ife.cl_raddr2 = {ra2[2], ra2[1], ra2[0]}; assign ifn.cl_raddr2 = {ra2[2], ra2[1], ra2[0]};
   assign ife.cl_waddr  = {wa[2], wa[1], wa[0]};    assign ifn.cl_waddr  = {wa[2], wa[1], wa[0]};
   assign ife.cl_wdata  = {wdt[2], wdt[1], wdt[0]}; assign ifn.cl_wdata  = {wdt[2], wdt[1], wdt[0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Abstract model: which phase is live, whether we sit in a gap, iterations and cycles spent in the phase.
   typedef struct packed {
      logic run; logic gap; logic stop; logic done; logic tmo;
      int phase; int nxt; int iters; int cyc;
   } model_t;

   model_t me, mn;

   function automatic model_t m_step(model_t m, logic early, logic st, logic ab, logic [NP-1:0] d, logic cv);
      model_t r;
      r = m;
      if (ab) return '0;
      if (m.run) begin
         if (d[m.phase[1:0]]) begin
            r.run = 1'b0;
            r.gap = 1'b1;
            if (m.phase == NP - 1) begin
               r.iters = m.iters + 1;
               r.stop  = (r.iters == MAX_IT) || (early && cv);
               r.nxt   = 0;
            end else begin
               r.nxt  = m.phase + 1;
               r.stop = 1'b0;
            end
         end else if (m.cyc + 1 == TMO_CYC) begin
            r.run  = 1'b0;
            r.done = 1'b1;
            r.tmo  = 1'b1;
         end else begin
            r.cyc = m.cyc + 1;
         end
      end else if (m.gap) begin
         r.gap = 1'b0;
         if (m.stop) r.done = 1'b1;
         else begin
            r.run   = 1'b1;
            r.phase = m.nxt;
            r.cyc   = 0;
         end
      end else if (st) begin
         r     = '0;
         r.run = 1'b1;
      end
      return r;
   endfunction

   task automatic chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", name, got, exp);
      end
   endtask

   task automatic check_one(string tag, model_t m, logic [NP-1:0] pen, logic bsy, logic ald, logic tmo,
                            logic [7:0] it, logic swe, logic [AW-1:0] swa, logic [AW-1:0] sr1,
                            logic [AW-1:0] sr2, logic [DW-1:0] swd);
      logic [NP-1:0] e_pen;
      e_pen = m.run ? NP'(1 << m.phase) : '0;
      chk({tag, ".phase_en"},    DW'(pen), DW'(e_pen));
      chk({tag, ".busy"},        DW'(bsy), DW'(m.run | m.gap));
      chk({tag, ".all_done"},    DW'(ald), DW'(m.done));
      chk({tag, ".timeout_err"}, DW'(tmo), DW'(m.tmo));
      chk({tag, ".iter_count"},  DW'(it),  DW'(m.iters));
      chk({tag, ".sram_we"},     DW'(swe), DW'(m.run ? cwe[m.phase[1:0]] : 1'b0));
      chk({tag, ".sram_waddr"},  DW'(swa), DW'(m.run ? wa[m.phase[1:0]]  : {AW{1'b1}}));
      chk({tag, ".sram_raddr1"}, DW'(sr1), DW'(m.run ? ra1[m.phase[1:0]] : {AW{1'b1}}));
      chk({tag, ".sram_raddr2"}, DW'(sr2), DW'(m.run ? ra2[m.phase[1:0]] : {AW{1'b1}}));
      chk({tag, ".sram_wdata"},  swd, m.run ? wdt[m.phase[1:0]] : '0);
   endtask

   task automatic check_both();
      check_one("e", me, ife.phase_en, ife.busy, ife.all_done, ife.timeout_err, ife.iter_count,
                ife.sram_we, ife.sram_waddr, ife.sram_raddr1, ife.sram_raddr2, ife.sram_wdata);
      check_one("n", mn, ifn.phase_en, ifn.busy, ifn.all_done, ifn.timeout_err, ifn.iter_count,
                ifn.sram_we, ifn.sram_waddr, ifn.sram_raddr1, ifn.sram_raddr2, ifn.sram_wdata);
   endtask

   task automatic tick();
      me = m_step(me, 1'b1, start, abort, pd, converged);
      mn = m_step(mn, 1'b0, start, abort, pd, converged);
      @(posedge clk);
      #1;
      check_both();
   endtask

   task automatic pulse_done(logic [NP-1:0] d);
      pd = d;
      tick();
      pd = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   typedef struct {
      logic          st;
      logic [NP-1:0] d;
      logic [NP-1:0] pen;
      logic [7:0]    it;
      logic          bsy;
      logic          ald;
   } vec_t;

   vec_t tbl [15];

   initial begin
      tbl[0]  = '{1'b1, 3'b000, 3'b001, 8'd0, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 3'b001, 3'b000, 8'd0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 3'b101, 3'b010, 8'd0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 3'b101, 3'b010, 8'd0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 3'b010, 3'b000, 8'd0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 3'b000, 3'b100, 8'd0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 3'b100, 3'b000, 8'd1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 3'b000, 3'b001, 8'd1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 3'b001, 3'b000, 8'd1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 3'b000, 3'b010, 8'd1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 3'b010, 3'b000, 8'd1, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 3'b000, 3'b100, 8'd1, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 3'b100, 3'b000, 8'd2, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 3'b000, 3'b000, 8'd2, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 3'b111, 3'b000, 8'd2, 1'b0, 1'b1};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; converged = 1'b0; pd = '0; cwe = '0;
      for (int k = 0; k < NP; k++) begin
         ra1[k] = '0; ra2[k] = '0; wa[k] = '0; wdt[k] = '0;
      end
      me = '0;
      mn = '0;
      repeat (3) @(posedge clk);
      #1;
      check_both();
      chk("reset.sram_raddr1", DW'(ife.sram_raddr1), DW'(11'h7FF));
      rst_n = 1'b1;

      // Two full iterations to MAX_ITERS, stray done bits and a start while busy
      for (int i = 0; i < 15; i++) begin
         start = tbl[i].st;
         pd    = tbl[i].d;
         tick();
         chk($sformatf("tbl%0d.phase_en", i),   DW'(ife.phase_en),   DW'(tbl[i].pen));
         chk($sformatf("tbl%0d.iter_count", i), DW'(ife.iter_count), DW'(tbl[i].it));
         chk($sformatf("tbl%0d.busy", i),       DW'(ife.busy),       DW'(tbl[i].bsy));
         chk($sformatf("tbl%0d.all_done", i),   DW'(ife.all_done),   DW'(tbl[i].ald));
      end
      start = 1'b0;
      pd    = '0;

      // Bus arbitration: only the active client reaches the SRAM port
      cwe    = 3'b011;
      wa[0]  = 11'h005;
      wa[1]  = 11'h123;
      wdt[0] = {32{8'h3C}};
      wdt[1] = {32{8'hA5}};
      pulse_start();
      pulse_done(3'b001);
      chk("t2.gap_we",    DW'(ife.sram_we),    DW'(1'b0));
      chk("t2.gap_waddr", DW'(ife.sram_waddr), DW'(11'h7FF));
      tick();
      chk("t2.run1_we",    DW'(ife.sram_we),    DW'(1'b1));
      chk("t2.run1_waddr", DW'(ife.sram_waddr), DW'(11'h123));
      chk("t2.run1_wdata", ife.sram_wdata, {32{8'hA5}});
      cwe = 3'b101;
      tick();
      chk("t2.run1_we_off", DW'(ife.sram_we), DW'(1'b0));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      cwe = '0;

      // Early stop on convergence vs. ignoring it
      pulse_start();
      pulse_done(3'b001); tick();
      pulse_done(3'b010); tick();
      converged = 1'b1;
      pulse_done(3'b100);
      converged = 1'b0;
      tick();
      chk("t3.e_all_done", DW'(ife.all_done),   DW'(1'b1));
      chk("t3.e_iter",     DW'(ife.iter_count), DW'(8'd1));
      chk("t3.n_phase_en", DW'(ifn.phase_en),   DW'(3'b001));
      pulse_done(3'b001); tick();
      pulse_done(3'b010); tick();
      pulse_done(3'b100); tick();
      chk("t3.n_all_done", DW'(ifn.all_done),   DW'(1'b1));
      chk("t3.n_iter",     DW'(ifn.iter_count), DW'(8'd2));
      chk("t3.e_iter_hold", DW'(ife.iter_count), DW'(8'd1));

      // Watchdog: phase 1 of iteration 2 never finishes
      pulse_start();
      pulse_done(3'b001); tick();
      pulse_done(3'b010); tick();
      pulse_done(3'b100); tick();
      pulse_done(3'b001); tick();
      repeat (TMO_CYC - 1) tick();
      chk("t4.still_run", DW'(ife.phase_en), DW'(3'b010));
      tick();
      chk("t4.all_done", DW'(ife.all_done),    DW'(1'b1));
      chk("t4.tmo",      DW'(ife.timeout_err), DW'(1'b1));
      chk("t4.iter",     DW'(ife.iter_count),  DW'(8'd1));

      // Abort beats phase_done; start while busy is ignored
      pulse_start();
      chk("t5.restart_tmo", DW'(ife.timeout_err), DW'(1'b0));
      pulse_done(3'b001); tick();
      pulse_done(3'b010); tick();
      pulse_done(3'b100); tick();
      pulse_start();
      chk("t5.start_ignored", DW'(ife.phase_en), DW'(3'b001));
      abort = 1'b1;
      pd    = 3'b001;
      tick();
      chk("t5.abort_pen",  DW'(ife.phase_en),   DW'(3'b000));
      chk("t5.abort_iter", DW'(ife.iter_count), DW'(8'd0));
      chk("t5.abort_busy", DW'(ife.busy),       DW'(1'b0));
      start = 1'b1;
      pd    = '0;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("t5.abort_vs_start", DW'(ife.busy), DW'(1'b0));

      // Asynchronous reset in the middle of RUN(2)
      pulse_start();
      pulse_done(3'b001); tick();
      pulse_done(3'b010); tick();
      chk("t6.run2", DW'(ife.phase_en), DW'(3'b100));
      #1 rst_n = 1'b0;
      #1;
      me = '0;
      mn = '0;
      check_both();
      #1 rst_n = 1'b1;
      pulse_start();
      chk("t6.restart_pen", DW'(ife.phase_en), DW'(3'b001));

      // Randomised traffic against the model
      begin
         int mode;
         mode = 0;
         for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) mode = int'($urandom_range(0, 2));
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 59) == 0);
            converged = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NP; k++) begin
               case (mode)
                  0:       pd[k] = ($urandom_range(0, 2) == 0);
                  1:       pd[k] = ($urandom_range(0, 11) == 0);
                  default: pd[k] = ($urandom_range(0, 29) == 0);
               endcase
               cwe[k] = $urandom_range(0, 1) == 1;
               ra1[k] = AW'($urandom());
               ra2[k] = AW'($urandom());
               wa[k]  = AW'($urandom());
               for (int w = 0; w < DW / 32; w++) wdt[k][w*32 +: 32] = $urandom();
            end
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
